psum_accumulate: RTL



---
 rtl/psum_accumulate_if.sv | 32 +++
 rtl/psum_accumulate.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/psum_accumulate_if.sv
// Purpose : bundles the partial-sum input stream and the accumulated-result output of psum_accumulate.
// Latency : n/a (wires only).
// Backpress: none; the stream has no ready, so the receiver takes a beat every cycle.
//
// Signals:
//   mode      - accumulation enabled only while high (CALCULATE)
//   data_e    - input beat valid
//   data_in   - 64 signed partial sums, DATA_WIDTH bits each
//   acc_out   - 64 signed final sums, registered
//   acc_e_out - one-cycle pulse marking acc_out valid
//   busy      - a frame is partially accumulated
// Modports: master = partial-sum stage side, slave = psum_accumulate side.
interface psum_accumulate_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         mode;
  logic                         data_e;
  logic [63:0][DATA_WIDTH-1:0]  data_in;
  logic [63:0][DATA_WIDTH-1:0]  acc_out;
  logic                         acc_e_out;
  logic                         busy;

  modport master (
    output mode, data_e, data_in,
    input  acc_out, acc_e_out, busy
  );

  modport slave (
    input  mode, data_e, data_in,
    output acc_out, acc_e_out, busy
  );
endinterface

// File: rtl/psum_accumulate.sv
// Purpose : sums PASS_NUM valid 64-channel partial-sum beats per output pixel and emits the 64 final sums.
// Latency : acc_out/acc_e_out update on the edge that samples the final beat (visible 1 cycle later).
// Backpress: none; a beat is accepted every cycle, and back-to-back frames need no bubble.
//
// Ports: clk, rst_n (async active-low); bus (psum_accumulate_if.slave): mode, data_e,
//        data_in[63:0] in; acc_out[63:0], acc_e_out, busy out.
// Build option: define PSUM_ACC_SAT_EN to saturate the output narrowing; otherwise it wraps.
// DATA_WIDTH must match the DATA_WIDTH of the connected interface instance.
module psum_accumulate #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 20,
  parameter int PASS_NUM   = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  psum_accumulate_if.slave bus
);

  localparam logic CALCULATE   = 1'b1;
  localparam logic DATAVALID   = 1'b1;
  localparam logic DATAINVALID = 1'b0;
  localparam logic RSTVALID    = 1'b0;

  localparam int              CNT_W    = (PASS_NUM > 1) ? $clog2(PASS_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_NUM - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic                            acc_ld;
  logic                            frame_done;

  logic signed [ACC_WIDTH-1:0]     acc [64];
  logic signed [ACC_WIDTH-1:0]     sum [64];
  logic [63:0][DATA_WIDTH-1:0]     narrow;
  logic [63:0][DATA_WIDTH-1:0]     acc_out_q;
  logic                            acc_e_q;

  // Next-state logic. A mode drop overrides any beat presented in the same
  // cycle and throws away the partial frame.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_ld     = 1'b0;
    frame_done = 1'b0;
    if (bus.mode != CALCULATE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (bus.data_e == DATAVALID) begin
      acc_ld = 1'b1;
      case (state)
        IDLE: begin
          if (PASS_NUM == 1) begin
            frame_done = 1'b1;
          end else begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (cnt == CNT_LAST) begin
            frame_done = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // The first beat of a frame adds to zero, so one adder serves both the load
  // and the accumulate case; whatever acc held from the last frame is ignored.
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      sum[k] = (state == ACCUM) ? acc[k] : '0;
      sum[k] = sum[k] + ACC_WIDTH'($signed(bus.data_in[k]));
    end
  end

`ifdef PSUM_ACC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    for (int k = 0; k < 64; k++) begin
      if (sum[k] > SAT_MAX) begin
        narrow[k] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (sum[k] < SAT_MIN) begin
        narrow[k] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        narrow[k] = sum[k][DATA_WIDTH-1:0];
      end
    end
  end
`else
  // Plain two's-complement wrap: keep the low DATA_WIDTH bits.
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      narrow[k] = sum[k][DATA_WIDTH-1:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RSTVALID) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_e_q   <= DATAINVALID;
      acc_out_q <= '0;
      for (int k = 0; k < 64; k++) begin
        acc[k] <= '0;
      end
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc_e_q <= frame_done ? DATAVALID : DATAINVALID;
      if (frame_done) begin
        acc_out_q <= narrow;
      end
      if (acc_ld) begin
        for (int k = 0; k < 64; k++) begin
          acc[k] <= sum[k];
        end
      end
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_e_out = acc_e_q;
  assign bus.busy      = (state == ACCUM);

endmodule
